// File: rtl/hello_scroller.sv
// hello_scroller: rotates "HELLO" plus blanks across NUM_DIGITS seven-segment
// displays. A prescaler paces the rotation; switches choose run/pause,
// direction and blanking. Segment outputs are active-low {g,f,e,d,c,b,a}.
module hello_scroller #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [2:0]              SW,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    TICK
);

    localparam int CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RING_W = 3 * NUM_DIGITS;

    localparam logic [2:0] CODE_H     = 3'd0;
    localparam logic [2:0] CODE_E     = 3'd1;
    localparam logic [2:0] CODE_L     = 3'd2;
    localparam logic [2:0] CODE_O     = 3'd3;
    localparam logic [2:0] CODE_BLANK = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    // Message occupies the five leftmost digits; everything else is blank.
    function automatic logic [RING_W-1:0] reset_ring();
        logic [RING_W-1:0] r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            r[3*k +: 3] = CODE_BLANK;
        end
        r[3*(NUM_DIGITS-1) +: 3] = CODE_H;
        r[3*(NUM_DIGITS-2) +: 3] = CODE_E;
        r[3*(NUM_DIGITS-3) +: 3] = CODE_L;
        r[3*(NUM_DIGITS-4) +: 3] = CODE_L;
        r[3*(NUM_DIGITS-5) +: 3] = CODE_O;
        return r;
    endfunction

    localparam logic [RING_W-1:0] RING_INIT = reset_ring();

    // Character code to active-low segments; unused codes show blank.
    function automatic logic [6:0] seg_decode(input logic [2:0] code);
        logic [6:0] s;
        case (code)
            CODE_H:  s = 7'b0001001;
            CODE_E:  s = 7'b0000110;
            CODE_L:  s = 7'b1000111;
            CODE_O:  s = 7'b1000000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic              tick_q, tick_d;
    logic              run;
    logic              dir_right;
    logic              blank;
    logic              rotate;

    assign run       = SW[0];
    assign dir_right = SW[1];
    assign blank     = SW[2];

    // Prescaler advance, rotation of the ring and tick generation.
    always_comb begin
        cnt_d  = cnt_q;
        ring_d = ring_q;
        rotate = 1'b0;
        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                rotate = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (rotate) begin
            if (dir_right) begin
                ring_d = {ring_q[2:0], ring_q[RING_W-1:3]};
            end else begin
                ring_d = {ring_q[RING_W-4:0], ring_q[RING_W-1:RING_W-3]};
            end
        end
        tick_d = rotate;
    end

    // State registers; reset restores the message and drops step progress.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= '0;
            ring_q <= RING_INIT;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ring_q <= ring_d;
            tick_q <= tick_d;
        end
    end

    // Zero-latency segment decode, forced off while blanking.
    always_comb begin
        HEX = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            HEX[7*k +: 7] = blank ? 7'b1111111 : seg_decode(ring_q[3*k +: 3]);
        end
    end

    assign TICK = tick_q;

endmodule

// File: doc/hello_scroller.md
Name: hello_scroller

Overview:
- Drives NUM_DIGITS seven-segment displays with the message "HELLO" followed by blanks, rotating one position per scroll step.
- A prescaler sets the step rate. Switches select run/pause, scroll direction and display blanking.
- Sits directly between the board clock, switches and HEX displays.
- Uses the standard active-low segment encoding {g,f,e,d,c,b,a}:
  - H = 0001001
  - E = 0000110
  - L = 1000111
  - O = 1000000
  - blank = 1111111

Parameters:
- NUM_DIGITS, 8, number of display digits and ring length. Must be >= 5.
- TICK_DIV, 25000000, clock cycles per scroll step. Must be >= 1.

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- SW  input  3  SW[0] run (1 = scroll, 0 = pause); SW[1] direction (0 = left, 1 = right); SW[2] blank (1 = all segments off).
- HEX  output  7*NUM_DIGITS  segments, active-low; digit k on HEX[7k+6:7k]; digit NUM_DIGITS-1 is leftmost.
- TICK  output  1  one-cycle pulse on every cycle in which the ring rotates.

Behaviour:
- Storage:
  - Ring of NUM_DIGITS 3-bit character codes: H=0, E=1, L=2, O=3, blank=4.
  - Codes 5–7 decode to blank.
  - HEX is a combinational decode of the ring registers (zero added latency), masked by SW[2].
- Reset (asynchronous, RESET=1):
  - Ring digits NUM_DIGITS-1 down to NUM_DIGITS-5 = H, E, L, L, O; all other digits = blank.
  - Prescaler count = 0; TICK = 0.
  - HEX reflects the reset ring immediately unless SW[2]=1.
  - Reset mid-scroll discards the current position and prescaler progress.
- Prescaler (counter 0..TICK_DIV-1, width clog2(TICK_DIV), minimum 1 bit):
  - While SW[0]=1: increments each cycle. At TICK_DIV-1 it wraps to 0 and the same edge performs one rotation.
  - While SW[0]=0: holds its value; no rotation.
  - Pausing and resuming continues the step from the held count; no restart.
  - TICK_DIV=1: rotation on every cycle while SW[0]=1.
- Rotation (on a rotation edge; SW[1] sampled on that edge only):
  - Left (SW[1]=0): digit k takes digit k-1; digit 0 takes digit NUM_DIGITS-1.
  - Right (SW[1]=1): digit k takes digit k+1; digit NUM_DIGITS-1 takes digit 0.
  - Changing SW[1] between steps affects only subsequent steps.
  - Ring contents are a permutation of the reset contents at all times; nothing is lost or duplicated.
- TICK:
  - Registered; high exactly in the cycle after each rotation edge, coincident with the new ring value on HEX.
  - Reset value 0.
- Blank (SW[2]=1):
  - HEX = all ones, combinationally.
  - Prescaler, ring and TICK continue to run unaffected.
  - Releasing SW[2] shows the current ring position.
- Switches are assumed synchronous to CLOCK_50 (synchronised upstream); no debounce in this block.

Test Plan (NUM_DIGITS=8, TICK_DIV=4; digits listed 7..0, _ = blank):
1. Assert RESET with SW=000, release → HEX shows H E L L O _ _ _, i.e. HEX[55:49]=0001001, HEX[6:0]=1111111; TICK=0; nothing changes over 20 cycles.
2. SW=001 from reset → first rotation on the 4th rising edge: E L L O _ _ _ H, with TICK=1 for one cycle. After 8 rotations (32 cycles) the display returns to H E L L O _ _ _.
3. SW=011 from reset → after 4 cycles: _ H E L L O _ _. Toggle SW[1] to 0 mid-step → the next rotation goes left and the display returns to H E L L O _ _ _.
4. SW=001 for 2 cycles, then SW=000 for 10 cycles, then SW=001 → first rotation occurs exactly 2 cycles after resume; no TICK during the pause.
5. SW=101 for 12 cycles → HEX all ones and TICK pulses 3 times. Set SW=001 → display shows L O _ _ _ H E L.
6. Assert RESET mid-step (count=2, ring already rotated once) → HEX returns asynchronously to H E L L O _ _ _. With SW=001 after release, the next rotation is 4 cycles later.
